// File: rtl/sobel_pkg.sv
// Shared types and helpers for the sobel magnitude stage.
// Provides default lane widths and the threshold/saturate helper.
package sobel_pkg;

  // Defaults for an 8-bit pipeline.
  // Stages use these or override with their own DATAWIDTH.
  localparam int SOBEL_DW = 8;
  localparam int LANE_W   = SOBEL_DW * 2;
  localparam int SUM_W    = SOBEL_DW * 2 + 1;

  // Handshake used across the sobel pipeline:
  //   beat moves upstream->stage on i_strobe && !o_busy,
  //   beat moves stage->downstream on o_strobe && !i_busy,
  //   o_busy is registered, so upstream can only ever
  //   overrun a stage by one beat (caught in a skid).

  // Zero below threshold, clamp to maxv, else pass through.
  function automatic logic [31:0] sat_thresh(
    input logic [31:0] sum,
    input logic [31:0] thr,
    input logic [31:0] maxv
  );
    if (sum < thr)
      return '0;
    else if (sum > maxv)
      return maxv;
    return sum;
  endfunction

endpackage

// File: rtl/sobel_skid.sv
// One-entry skid buffer with a registered busy for strobe/busy links.
// Ports: in_valid/in_data/busy upstream; out_valid/out_data/out_ready down.
module sobel_skid
  import sobel_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         ARESET,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         busy,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         sk_v;
  logic [W-1:0] sk_d;
  logic         acc;

  assign acc = in_valid && !busy;

  // A held skid beat always goes ahead of the live input.
  assign out_valid = sk_v || acc;
  assign out_data  = sk_v ? sk_d : in_data;

  always_ff @(posedge clk) begin
    if (ARESET) begin
      sk_v <= 1'b0;
      sk_d <= '0;
      busy <= 1'b1;
    end else begin
      if (sk_v) begin
        if (out_ready)
          sk_v <= 1'b0;
      end else if (acc && !out_ready) begin
        sk_v <= 1'b1;
        sk_d <= in_data;
      end
      // busy mirrors next-cycle skid occupancy.
      busy <= sk_v ? !out_ready : (acc && !out_ready);
    end
  end

endmodule

// File: rtl/sobel_mag.sv
// Sobel |Gx|+|Gy| stage: per-lane add, threshold, saturate, repack.
// In: packed_sum_x/y, i_strobe, in_tlast, i_busy. Out: packed_pix, o_strobe, out_tlast, o_busy, frame stats.
module sobel_mag
  import sobel_pkg::*;
#(
  parameter int PIXEL     = 3,
  parameter int DATAWIDTH = 8,
  parameter int THRESHOLD = 0,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         ARESET,
  input  logic [2*DATAWIDTH*PIXEL-1:0] packed_sum_x,
  input  logic [2*DATAWIDTH*PIXEL-1:0] packed_sum_y,
  input  logic                         i_strobe,
  output logic                         o_busy,
  input  logic                         in_tlast,
  output logic [DATAWIDTH*PIXEL-1:0]   packed_pix,
  output logic                         o_strobe,
  input  logic                         i_busy,
  output logic                         out_tlast,
  output logic [CNT_W-1:0]             frame_beats,
  output logic                         frame_done
);

  localparam int LW   = DATAWIDTH * 2;
  localparam int SW   = DATAWIDTH * 2 + 1;
  localparam int XW   = LW * PIXEL;
  localparam int PW   = 2 * XW + 1;
  localparam logic [31:0] MAXV = 32'((1 << DATAWIDTH) - 1);

  logic                  sk_valid;
  logic [PW-1:0]         sk_data;
  logic                  s1_adv;
  logic                  s2_adv;
  logic                  s1_v;
  logic [SW*PIXEL-1:0]   s1_sum;
  logic                  s1_last;
  logic [SW*PIXEL-1:0]   sum_c;
  logic [DATAWIDTH*PIXEL-1:0] pix_c;
  logic                  out_xfer;
  logic [CNT_W-1:0]      cnt;

  assign s2_adv   = !o_strobe || !i_busy;
  assign s1_adv   = !s1_v || s2_adv;
  assign out_xfer = o_strobe && !i_busy;

  sobel_skid #(.W(PW)) u_skid (
    .clk       (clk),
    .ARESET    (ARESET),
    .in_valid  (i_strobe),
    .in_data   ({in_tlast, packed_sum_x, packed_sum_y}),
    .busy      (o_busy),
    .out_valid (sk_valid),
    .out_data  (sk_data),
    .out_ready (s1_adv)
  );

  for (genvar g = 0; g < PIXEL; g++) begin : g_lane
    assign sum_c[g*SW +: SW] =
      SW'(sk_data[XW + g*LW +: LW]) + SW'(sk_data[g*LW +: LW]);
    assign pix_c[g*DATAWIDTH +: DATAWIDTH] = DATAWIDTH'(
      sat_thresh(32'(s1_sum[g*SW +: SW]), 32'(THRESHOLD), MAXV));
  end

  always_ff @(posedge clk) begin
    if (ARESET) begin
      s1_v       <= 1'b0;
      s1_sum     <= '0;
      s1_last    <= 1'b0;
      o_strobe   <= 1'b0;
      packed_pix <= '0;
      out_tlast  <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_v <= sk_valid;
        if (sk_valid) begin
          s1_sum  <= sum_c;
          s1_last <= sk_data[PW-1];
        end
      end
      if (s2_adv) begin
        o_strobe  <= s1_v;
        out_tlast <= s1_v && s1_last;
        if (s1_v)
          packed_pix <= pix_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ARESET) begin
      cnt         <= '0;
      frame_beats <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (out_xfer) begin
        if (out_tlast) begin
          frame_beats <= cnt + 1'b1;
          cnt         <= '0;
          frame_done  <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_mag.sv
// Self-checking bench for sobel_mag: directed literals plus random traffic
// against a queue-based reference of accepted beats.
module tb_sobel_mag;

  localparam int DW = 8;
  localparam int PX = 3;
  localparam int LW = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            ARESET;
  logic [LW*PX-1:0] sx, sy;
  logic            i_strobe, in_tlast, i_busy;

  logic            a_busy, a_strobe, a_tlast, a_fd;
  logic [DW*PX-1:0] a_pix;
  logic [CW-1:0]   a_fb;
  logic            b_busy, b_strobe, b_tlast, b_fd;
  logic [DW*PX-1:0] b_pix;
  logic [CW-1:0]   b_fb;

  sobel_mag #(.PIXEL(PX), .DATAWIDTH(DW), .THRESHOLD(0), .CNT_W(CW)) dut (
    .clk(clk), .ARESET(ARESET),
    .packed_sum_x(sx), .packed_sum_y(sy),
    .i_strobe(i_strobe), .o_busy(a_busy), .in_tlast(in_tlast),
    .packed_pix(a_pix), .o_strobe(a_strobe), .i_busy(i_busy),
    .out_tlast(a_tlast), .frame_beats(a_fb), .frame_done(a_fd)
  );

  sobel_mag #(.PIXEL(PX), .DATAWIDTH(DW), .THRESHOLD(64), .CNT_W(CW)) dut_t (
    .clk(clk), .ARESET(ARESET),
    .packed_sum_x(sx), .packed_sum_y(sy),
    .i_strobe(i_strobe), .o_busy(b_busy), .in_tlast(in_tlast),
    .packed_pix(b_pix), .o_strobe(b_strobe), .i_busy(i_busy),
    .out_tlast(b_tlast), .frame_beats(b_fb), .frame_done(b_fd)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [47:0] x;
    logic [47:0] y;
    bit          last;
  } beat_t;

  beat_t q[$];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_lane(input int unsigned x,
                                          input int unsigned y,
                                          input int unsigned thr);
    int unsigned s;
    s = x + y;
    if (s < thr) return 8'h00;
    if (s > 255) return 8'hFF;
    return 8'(s);
  endfunction

  function automatic logic [23:0] ref_pix(input logic [47:0] x,
                                          input logic [47:0] y,
                                          input int unsigned thr);
    logic [23:0] r;
    for (int i = 0; i < PX; i++)
      r[8*i +: 8] = ref_lane(int'(x[16*i +: 16]), int'(y[16*i +: 16]), thr);
    return r;
  endfunction

  bit          armed = 0, p_rst = 0, p_ib = 1;
  int          mcnt = 0;
  logic [15:0] mfb = '0;
  bit          fd_exp = 0;
  bit          rec = 0, rec_f = 0, saw_obusy = 0;
  int          rec_t[$];
  logic [7:0]  rec_v[$];
  logic [15:0] fb_q[$];
  beat_t       e;
  bit          xfer;

  always @(negedge clk) begin
    xfer = a_strobe && !i_busy;
    if (armed) begin
      chk("thr_dut_track", {b_busy, b_strobe, b_tlast, b_fd, b_fb},
          {a_busy, a_strobe, a_tlast, a_fd, a_fb});
      if (p_rst) begin
        chk("rst_vals", {a_busy, a_strobe, a_tlast, a_fd, a_fb, a_pix},
            {1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 24'h0});
      end else begin
        chk("frame_done", a_fd, fd_exp);
        chk("frame_beats", a_fb, mfb);
        if (!p_ib) chk("busy_free", a_busy, 1'b0);
      end
      if (xfer) begin
        if (q.size() == 0) begin
          chk("spurious_out", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          chk("pix_thr0", a_pix, ref_pix(e.x, e.y, 0));
          chk("pix_thr64", b_pix, ref_pix(e.x, e.y, 64));
          chk("tlast", a_tlast, e.last);
          if (rec) begin
            rec_t.push_back(cyc);
            rec_v.push_back(a_pix[7:0]);
          end
        end
      end
      if (rec_f && a_fd) fb_q.push_back(a_fb);
      if (rec && a_busy) saw_obusy = 1;
    end
    fd_exp = 0;
    if (xfer && !ARESET) begin
      if (a_tlast) begin
        mfb = 16'(mcnt + 1);
        mcnt = 0;
        fd_exp = 1;
      end else begin
        mcnt = (mcnt + 1) % 65536;
      end
    end
    if (i_strobe && !a_busy && !ARESET)
      q.push_back('{x: sx, y: sy, last: in_tlast});
    if (ARESET) begin
      q.delete();
      mcnt = 0;
      mfb = '0;
      fd_exp = 0;
    end
    p_rst = ARESET;
    p_ib = i_busy;
    armed = 1;
  end

  task automatic send(input logic [47:0] x, input logic [47:0] y,
                      input bit last);
    int w;
    w = 0;
    sx = x;
    sy = y;
    in_tlast = last;
    i_strobe = 1'b1;
    @(negedge clk);
    while (a_busy && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (w >= 200) chk("send_timeout", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    i_strobe = 1'b0;
    in_tlast = 1'b0;
  endtask

  task automatic send_lat(input string nm, input logic [47:0] x,
                          input logic [47:0] y,
                          input logic [23:0] ea, input logic [23:0] eb);
    send(x, y, 1'b0);
    @(negedge clk);
    chk({nm, "_lat1"}, a_strobe, 1'b0);
    @(negedge clk);
    chk({nm, "_lat2"}, a_strobe, 1'b1);
    chk({nm, "_a"}, a_pix, ea);
    chk({nm, "_b"}, b_pix, eb);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    ARESET = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rl();
    unique case ($urandom_range(0, 2))
      0: return 16'($urandom);
      1: return 16'($urandom_range(0, 256));
      default: return 16'($urandom_range(0, 128));
    endcase
  endfunction

  int  drop_cyc;
  bit  rnd_on;
  bit  gap_ok;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ARESET = 1'b1;
    i_strobe = 1'b0;
    in_tlast = 1'b0;
    i_busy = 1'b0;
    sx = '0;
    sy = '0;
    repeat (3) @(posedge clk);
    #1;
    ARESET = 1'b0;
    @(posedge clk);
    #1;

    send_lat("basic_sat", 48'hFFFF_00F0_0010, 48'hFFFF_0020_0020,
             24'hFFFF30, 24'hFFFF00);
    send_lat("sat_edge", 48'h0020_007F_007F, 48'h001F_007F_0080,
             24'h3FFEFF, 24'h00FEFF);
    send_lat("thr_edge", 48'h0000_003F_0020, 48'h0000_0000_0020,
             24'h003F40, 24'h000040);
    repeat (3) @(posedge clk);
    #1;

    rec = 1;
    saw_obusy = 0;
    fork
      begin
        for (int k = 1; k <= 8; k++)
          send(48'(k), 48'h0, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        i_busy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        i_busy = 1'b0;
        drop_cyc = cyc;
      end
    join
    repeat (6) @(negedge clk);
    rec = 0;
    chk("bp_obusy_seen", saw_obusy, 1'b1);
    chk("bp_count", rec_v.size(), 8);
    for (int i = 0; i < rec_v.size() && i < 8; i++)
      chk("bp_order", rec_v[i], 8'(i + 1));
    gap_ok = 1;
    for (int i = 1; i < rec_t.size(); i++)
      if (rec_t[i-1] >= drop_cyc && rec_t[i] - rec_t[i-1] != 1) gap_ok = 0;
    chk("bp_no_gaps", gap_ok, 1'b1);
    @(posedge clk);
    #1;

    do_reset();
    rec_f = 1;
    for (int k = 1; k <= 6; k++) send(48'(k * 3), 48'(k), k == 6);
    for (int k = 1; k <= 2; k++) send(48'(k), 48'(k), k == 2);
    repeat (6) @(posedge clk);
    #1;
    rec_f = 0;
    chk("frame_pulses", fb_q.size(), 2);
    if (fb_q.size() == 2) begin
      chk("frame_len0", fb_q[0], 16'd6);
      chk("frame_len1", fb_q[1], 16'd2);
    end

    i_busy = 1'b1;
    sx = 48'h0001_0002_0003;
    sy = '0;
    i_strobe = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("skid_full", a_busy, 1'b1);
    ARESET = 1'b1;
    i_strobe = 1'b0;
    @(posedge clk);
    #1;
    ARESET = 1'b0;
    i_busy = 1'b0;
    @(negedge clk);
    chk("mid_rst_strobe", a_strobe, 1'b0);
    chk("mid_rst_busy", a_busy, 1'b1);
    chk("mid_rst_fb", a_fb, 16'h0);
    @(negedge clk);
    chk("mid_rst_busy_drop", a_busy, 1'b0);
    @(posedge clk);
    #1;
    send_lat("post_rst", 48'h0041_0100_0005, 48'h0000_0000_0005,
             24'h41FF0A, 24'h41FF00);

    rnd_on = 1;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
          end
          send({rl(), rl(), rl()}, {rl(), rl(), rl()},
               $urandom_range(0, 7) == 0);
        end
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          i_busy = ($urandom_range(0, 2) == 0);
          @(posedge clk);
          #1;
        end
        i_busy = 1'b0;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_mag.md
Name: sobel_mag

Overview:
- Downstream neighbour of the X/Y subtraction stage.
- Consumes the per-lane Gx and Gy magnitudes (PIXEL lanes, each 2*DATAWIDTH wide) and forms |Gx|+|Gy|.
- Applies an edge threshold, saturates each lane to a DATAWIDTH output pixel and repacks the lanes for the AXI-Stream output wrapper.
- Uses the same strobe/busy handshake as the rest of the sobel pipeline, forwards tlast, and reports per-frame beat counts.

Parameters:
- PIXEL, 3, pixels (lanes) per beat.
- DATAWIDTH, 8, output pixel width; input lanes are 2*DATAWIDTH.
- THRESHOLD, 0, lane sums strictly below this value output 0.
- CNT_W, 16, width of the frame beat counter.

Ports:
- clk  in  1  rising-edge clock.
- ARESET  in  1  synchronous, active-high reset.
- packed_sum_x  in  2*DATAWIDTH*PIXEL  Gx lanes; lane i at bits [2*DATAWIDTH*i +: 2*DATAWIDTH].
- packed_sum_y  in  2*DATAWIDTH*PIXEL  Gy lanes, same packing.
- i_strobe  in  1  upstream beat valid.
- o_busy  out  1  tells upstream not to present new beats (registered).
- in_tlast  in  1  last beat of frame, qualified by i_strobe.
- packed_pix  out  DATAWIDTH*PIXEL  output pixels; lane i at bits [DATAWIDTH*i +: DATAWIDTH].
- o_strobe  out  1  output beat valid.
- i_busy  in  1  downstream stall.
- out_tlast  out  1  tlast aligned with its packed_pix beat.
- frame_beats  out  CNT_W  beat count of the last completed frame.
- frame_done  out  1  one-cycle pulse when a tlast beat leaves.

Behaviour:
- Clock and reset: single clock clk. ARESET is synchronous, active-high.
- Reset values: o_busy=1, o_strobe=0, out_tlast=0, packed_pix=0, frame_beats=0, frame_done=0. All internal valids, the skid buffer and the beat counter clear.
- Reset is honoured mid-stream; in-flight beats are discarded. o_busy drops to 0 on the first cycle after ARESET deasserts.
- Input transfer: i_strobe && !o_busy. Output transfer: o_strobe && !i_busy.
- Pipeline: S1 and S2 registers plus a one-entry skid register SK.
  - S1 computes sum[i] = x[i] + y[i] at 2*DATAWIDTH+1 bits. No overflow is possible.
  - S2 computes pix[i] = 0 if sum[i] < THRESHOLD; else 2^DATAWIDTH-1 if sum[i] > 2^DATAWIDTH-1; else sum[i][DATAWIDTH-1:0].
  - S2 drives packed_pix, o_strobe and out_tlast.
  - Lanes are independent and unsigned; inputs are already non-negative.
- Latency: 2 cycles from input transfer to o_strobe when there is no stall.
- Advance rules:
  - S2 loads when it is empty or its beat transfers in that cycle.
  - S1 moves to S2 under the same condition.
  - S1 loads when it is empty or moving on, taking from SK if SK is occupied, otherwise from the accepted input beat.
- Skid rules:
  - An accepted input beat that cannot enter S1 goes to SK, and o_busy is set next cycle.
  - When SK drains into S1, o_busy clears next cycle.
  - SK being occupied is the only cause of o_busy=1 outside reset.
- While o_busy=1, inputs are ignored; upstream holds its data.
- Ordering: beats are never lost, duplicated or reordered. tlast travels with its data through S1, SK and S2.
- Simultaneous events:
  - Input accept and output transfer in the same cycle both take effect.
  - SK drain and a new input in the same cycle cannot happen, because o_busy=1 while SK is full.
- Beat counter: increments on each output transfer.
  - On a transfer with out_tlast=1: frame_beats <= count+1, counter <= 0, frame_done=1 for exactly that cycle.
  - The counter wraps modulo 2^CNT_W with no flag.
- packed_pix holds its value while o_strobe=1 && i_busy=1.

Decomposition:
- sobel_pkg holds:
  - the lane-width localparams (DATAWIDTH*2, DATAWIDTH*2+1);
  - a sat_thresh function (sum, threshold -> pixel);
  - the shared strobe/busy handshake notes.
- One sub-module, sobel_skid (a one-entry skid plus the valid/busy logic, parameterised on payload width), reusable by the other pipeline stages.
- Arithmetic stays in sobel_mag as a generate loop over PIXEL.

Test Plan (DATAWIDTH=8, PIXEL=3):
- Basic: lane0 x=0x0010, y=0x0020, i_busy=0 -> lane0 pix=0x30 and o_strobe exactly 2 cycles after accept.
- Saturation: x=0x00F0, y=0x0020 -> 0xFF; x=0xFFFF, y=0xFFFF -> 0xFF; x=0x007F, y=0x0080 -> 0xFF; x=0x007F, y=0x007F -> 0xFE.
- Threshold=0x40: sum 0x3F -> 0x00; sum 0x40 -> 0x40; lanes mixed within one beat are handled independently.
- Backpressure: stream 8 beats (lane0=1..8) back-to-back with i_busy high for cycles 3-7.
  - o_busy asserts within 1 cycle of the first skid fill.
  - Output is exactly 1..8 in order, with no gaps once i_busy drops.
- Frame: 6 beats with in_tlast on the 6th, then 2 beats with tlast on the 2nd.
  - out_tlast appears only on beats 6 and 8.
  - frame_done pulses twice; frame_beats reads 6, then 2.
- Reset mid-operation: assert ARESET for 1 cycle with S1, S2 and SK all full.
  - Next cycle: o_strobe=0, o_busy=1, frame_beats=0.
  - Following cycle: o_busy=0; the first new beat emerges correctly.
